// File: rtl/serial_bus_bridge.sv
// serial_bus_bridge: CPU word access to a narrow serial bus.
// A latched request is split into BEATS = WORD_W/BUS_W bus beats,
// least-significant beat first. Writes stream one beat per cycle.
// Reads collect one beat per cycle with bus_rvalid high.
// The transfer ends with a one-cycle ack pulse.
// Optional feature: define SERIAL_BUS_BRIDGE_TIMEOUT_EN to add a read
// stall timeout. When the stall limit is reached, the read ends early
// with ack and err pulsed together.
module serial_bus_bridge #(
  parameter int WORD_W      = 16,
  parameter int BUS_W       = 8,
  parameter int ADDR_W      = 9,
  parameter int TIMEOUT_CYC = 16,
  localparam int BEATS      = WORD_W / BUS_W,
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [BEAT_W-1:0] bus_beat,
  output logic              bus_we,
  output logic              bus_re,
  output logic [BUS_W-1:0]  bus_dout,
  input  logic [BUS_W-1:0]  bus_din,
  input  logic              bus_rvalid
);

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  state_t            state_reg;
  // Beats of the write word that have not yet been driven.
  // The next beat to drive is always the low slice.
  logic [WORD_W-1:0] wshift_reg;
  logic [BEATS-1:0]  slice_sel;
  logic              last_beat;

`ifdef SERIAL_BUS_BRIDGE_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_reg;
  logic               err_reg;
  assign err = err_reg;
`else
  // Reads wait forever; the timeout limit has no effect in this build.
  assign err = 1'b0;
  wire unused_timeout = (TIMEOUT_CYC > 0);
`endif

  // One-hot decode of the current beat, used to pick the rdata slice to load.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice_sel
      assign slice_sel[gi] = (bus_beat == BEAT_W'(gi));
    end
  endgenerate

  assign last_beat = (bus_beat == BEAT_W'(BEATS - 1));

  // Transfer FSM. All bus-facing outputs are registered alongside the state,
  // so address and beat index are stable for the full beat cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      wshift_reg <= '0;
      rdata      <= '0;
      ack        <= 1'b0;
      busy       <= 1'b0;
      bus_addr   <= '0;
      bus_beat   <= '0;
      bus_we     <= 1'b0;
      bus_re     <= 1'b0;
      bus_dout   <= '0;
`ifdef SERIAL_BUS_BRIDGE_TIMEOUT_EN
      stall_reg  <= '0;
      err_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            busy     <= 1'b1;
            bus_addr <= addr;
            bus_beat <= '0;
`ifdef SERIAL_BUS_BRIDGE_TIMEOUT_EN
            stall_reg <= '0;
`endif
            if (we) begin
              state_reg  <= WR;
              bus_we     <= 1'b1;
              bus_dout   <= wdata[BUS_W-1:0];
              wshift_reg <= wdata >> BUS_W;
            end else begin
              state_reg <= RD;
              bus_re    <= 1'b1;
            end
          end
        end

        WR: begin
          if (last_beat) begin
            state_reg <= DONE;
            bus_we    <= 1'b0;
            bus_dout  <= '0;
            ack       <= 1'b1;
          end else begin
            bus_beat   <= bus_beat + 1'b1;
            bus_dout   <= wshift_reg[BUS_W-1:0];
            wshift_reg <= wshift_reg >> BUS_W;
          end
        end

        RD: begin
          if (bus_rvalid) begin
            // Only the slice for the current beat changes.
            // Slices that are not written keep their earlier contents.
            for (int i = 0; i < BEATS; i++) begin
              if (slice_sel[i]) rdata[i*BUS_W +: BUS_W] <= bus_din;
            end
`ifdef SERIAL_BUS_BRIDGE_TIMEOUT_EN
            stall_reg <= '0;
`endif
            if (last_beat) begin
              state_reg <= DONE;
              bus_re    <= 1'b0;
              ack       <= 1'b1;
            end else begin
              bus_beat <= bus_beat + 1'b1;
            end
          end
`ifdef SERIAL_BUS_BRIDGE_TIMEOUT_EN
          else if (stall_reg == STALL_W'(TIMEOUT_CYC - 1)) begin
            // This stall cycle brings the count to TIMEOUT_CYC, so give up.
            state_reg <= DONE;
            bus_re    <= 1'b0;
            ack       <= 1'b1;
            err_reg   <= 1'b1;
          end else begin
            stall_reg <= stall_reg + 1'b1;
          end
`endif
        end

        DONE: begin
          state_reg <= IDLE;
          ack       <= 1'b0;
          busy      <= 1'b0;
          bus_beat  <= '0;
`ifdef SERIAL_BUS_BRIDGE_TIMEOUT_EN
          err_reg   <= 1'b0;
`endif
        end

        default: begin
          state_reg <= IDLE;
          ack       <= 1'b0;
          busy      <= 1'b0;
          bus_we    <= 1'b0;
          bus_re    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bus_bridge.sv
// Testbench for serial_bus_bridge. It uses directed transfers with expected
// results worked out by hand.
// The stimulus process pushes the expected completions and write beats.
// Separate monitors pop those entries and compare them when the DUT acks or
// drives a write beat.
// Two instances are used: the default 16/8 configuration and a 32/8 one.
module tb_serial_bus_bridge;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // 16-bit instance signals
  logic        req, we, ack, err, busy, bus_we, bus_re, bus_rvalid;
  logic [8:0]  addr, bus_addr;
  logic [15:0] wdata, rdata;
  logic [0:0]  bus_beat;
  logic [7:0]  bus_dout, bus_din;

  // 32-bit instance signals
  logic        req32, ack32, err32, busy32, bus_we32, bus_re32, bus_rvalid32;
  logic [8:0]  addr32, bus_addr32;
  logic [31:0] rdata32;
  logic [1:0]  bus_beat32;
  logic [7:0]  bus_dout32, bus_din32;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } cmp_t;

  typedef struct {
    logic [8:0] addr;
    logic       beat;
    logic [7:0] dout;
    int         cyc;
  } wbeat_t;

  cmp_t   cq[$];
  cmp_t   cq32[$];
  wbeat_t wq[$];
  cmp_t   mon_e;
  cmp_t   mon_e32;
  wbeat_t mon_w;

  serial_bus_bridge u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .err(err), .busy(busy), .bus_addr(bus_addr),
    .bus_beat(bus_beat), .bus_we(bus_we), .bus_re(bus_re), .bus_dout(bus_dout),
    .bus_din(bus_din), .bus_rvalid(bus_rvalid)
  );

  serial_bus_bridge #(.WORD_W(32), .BUS_W(8)) u_dut32 (
    .clk(clk), .rst(rst), .req(req32), .we(1'b0), .addr(addr32), .wdata(32'h0),
    .rdata(rdata32), .ack(ack32), .err(err32), .busy(busy32), .bus_addr(bus_addr32),
    .bus_beat(bus_beat32), .bus_we(bus_we32), .bus_re(bus_re32), .bus_dout(bus_dout32),
    .bus_din(bus_din32), .bus_rvalid(bus_rvalid32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  // Completion and write-beat monitor for the 16-bit instance.
  always @(negedge clk) begin
    if (ack) begin
      if (cq.size() == 0) begin
        check("unexpected_ack16", 32'(ack), 32'd0);
      end else begin
        mon_e = cq.pop_front();
        $display("txn16 ack cyc=%0d rdata=%h err=%b", cyc, rdata, err);
        check("rdata16", 32'(rdata), mon_e.rdata);
        check("err16", 32'(err), 32'(mon_e.err));
        check("ack_cyc16", cyc, mon_e.cyc);
      end
    end else if (err) begin
      check("err_without_ack16", 32'(err), 32'd0);
    end
    if (bus_we) begin
      if (wq.size() == 0) begin
        check("unexpected_bus_we16", 32'(bus_we), 32'd0);
      end else begin
        mon_w = wq.pop_front();
        check("bus_addr16", 32'(bus_addr), 32'(mon_w.addr));
        check("bus_beat16", 32'(bus_beat), 32'(mon_w.beat));
        check("bus_dout16", 32'(bus_dout), 32'(mon_w.dout));
        check("beat_cyc16", cyc, mon_w.cyc);
      end
    end
    // A read request is present only while busy, outside the write beats and the ack cycle.
    check("bus_re16", 32'(bus_re), 32'(busy && !bus_we && !ack));
  end

  // Completion monitor for the 32-bit instance.
  always @(negedge clk) begin
    if (ack32) begin
      if (cq32.size() == 0) begin
        check("unexpected_ack32", 32'(ack32), 32'd0);
      end else begin
        mon_e32 = cq32.pop_front();
        $display("txn32 ack cyc=%0d rdata=%h err=%b", cyc, rdata32, err32);
        check("rdata32", rdata32, mon_e32.rdata);
        check("err32", 32'(err32), 32'(mon_e32.err));
        check("ack_cyc32", cyc, mon_e32.cyc);
      end
    end
  end

  task automatic wait_idle16();
    for (int k = 0; k < 64 && busy; k++) @(negedge clk);
    check("idle_bound16", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_bus_addr"}, 32'(bus_addr), 32'd0);
    check({tag, "_bus_beat"}, 32'(bus_beat), 32'd0);
    check({tag, "_bus_we"}, 32'(bus_we), 32'd0);
    check({tag, "_bus_re"}, 32'(bus_re), 32'd0);
    check({tag, "_bus_dout"}, 32'(bus_dout), 32'd0);
  endtask

  // Read on the 16-bit instance. Element j of vmask/dins is driven in RD cycle j+1.
  task automatic do_read16(input logic [8:0] a, input int ncyc, input logic [7:0] vmask,
                           input logic [63:0] dins, input logic [15:0] exp_rd,
                           input logic exp_err, input int lat, input logic poke);
    int n0;
    @(negedge clk);
    n0 = cyc; req = 1'b1; we = 1'b0; addr = a;
    cq.push_back('{{16'h0, exp_rd}, exp_err, n0 + lat});
    for (int j = 0; j < ncyc; j++) begin
      @(negedge clk);
      req = poke && (j == 1);
      we = 1'b1;
      bus_rvalid = vmask[j];
      bus_din = dins[j*8 +: 8];
    end
    @(negedge clk);
    req = 1'b0; bus_rvalid = 1'b0; bus_din = 8'h00;
    wait_idle16();
  endtask

  // Write on the 16-bit instance. bus_rvalid is kept high throughout, and it must be ignored.
  task automatic do_write16(input logic [8:0] a, input logic [15:0] wd, input logic [15:0] cur_rd);
    int n0;
    @(negedge clk);
    n0 = cyc; req = 1'b1; we = 1'b1; addr = a; wdata = wd;
    bus_rvalid = 1'b1; bus_din = 8'hFF;
    wq.push_back('{a, 1'b0, wd[7:0], n0 + 1});
    wq.push_back('{a, 1'b1, wd[15:8], n0 + 2});
    cq.push_back('{{16'h0, cur_rd}, 1'b0, n0 + 3});
    @(negedge clk);
    req = 1'b0;
    wait_idle16();
    bus_rvalid = 1'b0;
  endtask

  initial begin
    int n0;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    bus_din = '0; bus_rvalid = 1'b0;
    req32 = 1'b0; addr32 = '0; bus_din32 = '0; bus_rvalid32 = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_rdata32", rdata32, 32'd0);
    check("reset_busy32", 32'(busy32), 32'd0);
    rst = 1'b0;

    // Basic read: beats AB, then 10.
    do_read16(9'd0, 2, 8'b11, 64'h10AB, 16'h10AB, 1'b0, 3, 1'b0);
    // Basic write with stray bus_rvalid.
    do_write16(9'd2, 16'h4CAB, 16'h10AB);
    // Read at the top address with two stall cycles between beats.
    // A req pulse during the read must be ignored.
    do_read16(9'h1FF, 4, 8'b1001, 64'hBE0000EF, 16'hBEEF, 1'b0, 5, 1'b1);

    // req is held through a write; the second transfer starts on the IDLE
    // cycle after DONE and latches the new wdata.
    @(negedge clk);
    n0 = cyc; req = 1'b1; we = 1'b1; addr = 9'd5; wdata = 16'h1357;
    wq.push_back('{9'd5, 1'b0, 8'h57, n0 + 1});
    wq.push_back('{9'd5, 1'b1, 8'h13, n0 + 2});
    cq.push_back('{32'h0000BEEF, 1'b0, n0 + 3});
    wq.push_back('{9'd5, 1'b0, 8'h68, n0 + 5});
    wq.push_back('{9'd5, 1'b1, 8'h24, n0 + 6});
    cq.push_back('{32'h0000BEEF, 1'b0, n0 + 7});
    @(negedge clk);
    wdata = 16'h2468;
    repeat (4) @(negedge clk);
    req = 1'b0;
    wait_idle16();

    // Reset during the second WR cycle abandons the write without an ack.
    @(negedge clk);
    n0 = cyc; req = 1'b1; we = 1'b1; addr = 9'd7; wdata = 16'h9A5E;
    wq.push_back('{9'd7, 1'b0, 8'h5E, n0 + 1});
    wq.push_back('{9'd7, 1'b1, 8'h9A, n0 + 2});
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abandon");
    rst = 1'b0;
    do_read16(9'd3, 2, 8'b11, 64'h2211, 16'h2211, 1'b0, 3, 1'b0);

`ifdef SERIAL_BUS_BRIDGE_TIMEOUT_EN
    // Beat 0 is accepted, then the bus stalls. After 16 stall cycles the read
    // ends with ack and err together. The upper byte keeps its old value.
    do_read16(9'd1, 1, 8'b1, 64'hCD, 16'h22CD, 1'b1, 18, 1'b0);
`endif

    // 32-bit read with two stall cycles between beats 1 and 2.
    @(negedge clk);
    n0 = cyc; req32 = 1'b1; addr32 = 9'h0AA;
    cq32.push_back('{32'h12345678, 1'b0, n0 + 7});
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      req32 = 1'b0;
      bus_rvalid32 = (j != 2) && (j != 3);
      case (j)
        0: bus_din32 = 8'h78;
        1: bus_din32 = 8'h56;
        4: bus_din32 = 8'h34;
        5: bus_din32 = 8'h12;
        default: bus_din32 = 8'h00;
      endcase
    end
    @(negedge clk);
    bus_rvalid32 = 1'b0;
    for (int k = 0; k < 64 && busy32; k++) @(negedge clk);
    check("idle_bound32", 32'(busy32), 32'd0);

    repeat (2) @(negedge clk);
    check("pending_acks16", cq.size(), 32'd0);
    check("pending_beats16", wq.size(), 32'd0);
    check("pending_acks32", cq32.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_bus_bridge.md
SERIAL_BUS_BRIDGE -- requirements
Module: serial_bus_bridge

Interface
REQ-001 SHALL have parameter WORD_W, default 16: CPU-side word width in bits.
REQ-002 SHALL have parameter BUS_W, default 8: serial bus beat width; WORD_W SHALL be an integer multiple of BUS_W; BEATS = WORD_W/BUS_W, with BEATS>=1.
REQ-003 SHALL have parameter ADDR_W, default 9: word address width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 16: read stall limit, in cycles.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 req  input  1  transfer request, sampled in IDLE only.
REQ-008 we  input  1  1=write, 0=read; sampled with req.
REQ-009 addr  input  ADDR_W  word address; sampled with req.
REQ-010 wdata  input  WORD_W  write word; sampled with req.
REQ-011 rdata  output  WORD_W  assembled read word.
REQ-012 ack  output  1  one-cycle completion pulse.
REQ-013 err  output  1  one-cycle pulse coincident with ack on a timed-out read.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 bus_addr  output  ADDR_W  latched word address, held for the whole transfer.
REQ-016 bus_beat  output  clog2(BEATS), min 1  current beat index.
REQ-017 bus_we  output  1  write beat strobe.
REQ-018 bus_re  output  1  read request, held high for the whole read.
REQ-019 bus_dout  output  BUS_W  write beat data.
REQ-020 bus_din  input  BUS_W  read beat data.
REQ-021 bus_rvalid  input  1  bus_din valid this cycle.

Function
REQ-022 FSM states SHALL be IDLE, WR, RD, DONE.
REQ-023 IDLE with req=1: latch we/addr/wdata; beat=0; go to WR if we=1, else RD. req while busy SHALL be ignored and not queued.
REQ-024 Beat order SHALL be least-significant first: beat k = word bits [k*BUS_W +: BUS_W].
REQ-025 WR: each cycle bus_we=1, bus_dout=wdata beat[bus_beat]; beat increments without stall; after beat BEATS-1, go to DONE.
REQ-026 RD: bus_re=1. A cycle with bus_rvalid=1 SHALL write bus_din into rdata slice [bus_beat] and increment the beat. After beat BEATS-1 is accepted, go to DONE.
REQ-027 Slices of rdata not yet written in a read SHALL keep their prior values. Outside RD, bus_rvalid SHALL be ignored.
REQ-028 DONE: ack=1 for exactly one cycle, then IDLE; a req in the DONE cycle SHALL be ignored.
REQ-029 Latency, req sample to ack: write = BEATS+1 cycles; read = (cycles in RD)+1; minimum read = BEATS+1.
REQ-030 bus_addr and bus_beat SHALL be stable for the whole cycle in which a beat is driven or accepted; bus_we and bus_re SHALL be 0 in IDLE and DONE.
REQ-031 rdata SHALL hold its value until the next accepted read beat.

Reset
REQ-032 With rst=1 at a clock edge: state=IDLE and beat=0; rdata, ack, err, busy, bus_addr, bus_beat, bus_we, bus_re and bus_dout all =0.
REQ-033 Reset during WR/RD/DONE SHALL abandon the transfer with no ack or err pulse; rst SHALL take priority over req.

Configuration
REQ-034 With macro SERIAL_BUS_BRIDGE_TIMEOUT_EN defined: a stall counter SHALL clear on entry to RD and on each accepted beat, and increment on each RD cycle with bus_rvalid=0.
REQ-035 When the stall counter reaches TIMEOUT_CYC, the bridge SHALL go to DONE and assert ack=1 and err=1 together. Slices of rdata already written SHALL keep the values written.
REQ-036 Without SERIAL_BUS_BRIDGE_TIMEOUT_EN: no stall counter; err SHALL be constant 0; RD SHALL wait indefinitely.

Verification
REQ-037 Defaults, read addr=0, bus_rvalid=1 with bus_din AB then 10 -> rdata=16'h10AB, ack 3 cycles after req, err=0.
REQ-038 Defaults, write addr=2, wdata=16'h4CAB -> bus_we for 2 cycles, bus_dout AB then 4C, bus_beat 0 then 1, bus_addr=2, ack at cycle 3.
REQ-039 WORD_W=32, BUS_W=8, read with bus_rvalid low for 2 cycles between beats 1 and 2, beats 78,56,34,12 -> rdata=32'h12345678, ack at cycle 7.
REQ-040 SERIAL_BUS_BRIDGE_TIMEOUT_EN, defaults, read with beat 0=CD and then bus_rvalid=0 -> ack=err=1 after 16 stall cycles, rdata[7:0]=CD, upper byte unchanged.
REQ-041 rst=1 in the second WR cycle -> all outputs 0 on the next cycle, no ack; a new read then completes normally.
REQ-042 req held high through a write -> exactly one transfer until IDLE; second transfer starts on the cycle after the DONE cycle.
